// File: rtl/prog_sequencer.sv
// Run controller for the fetch unit: launches programs 0..NUM_PROGS-1 back to back,
// holds the core in Init between them, measures run length and flags runaways.
module prog_sequencer #(
    parameter int unsigned NUM_PROGS   = 3,
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned MAX_CYCLES  = 4095
) (
    input  logic        CLK,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic        Halt,
    output logic        Init,
    output logic [1:0]  ProgState,
    output logic        Busy,
    output logic        Done,
    output logic        Timeout,
    output logic        ProgDone,
    output logic [15:0] CycleCount
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StNext, StDone} state_e;

    localparam logic [1:0]  LastIdx   = 2'(NUM_PROGS - 1);
    localparam logic [15:0] LoadLast  = 16'(INIT_CYCLES - 1);
    localparam logic [16:0] MaxCycles = 17'(MAX_CYCLES);

    state_e      state_q;
    logic [1:0]  idx_q;
    logic [15:0] load_cnt_q;
    logic [15:0] run_cnt_q;

    logic [16:0] run_plus_one;
    logic [15:0] run_inc;
    logic        halt_seen;
    logic        limit_hit;

    assign run_plus_one = {1'b0, run_cnt_q} + 17'd1;
    assign run_inc      = (run_cnt_q == 16'hFFFF) ? run_cnt_q : run_plus_one[15:0];
    // run_cnt_q == 0 is the blank cycle: Halt still reflects the core's pre-run state.
    assign halt_seen    = Halt && (run_cnt_q != 16'd0);
    assign limit_hit    = (run_plus_one == MaxCycles);

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= StIdle;
            idx_q      <= 2'd0;
            load_cnt_q <= 16'd0;
            run_cnt_q  <= 16'd0;
            Init       <= 1'b1;
            ProgState  <= 2'd0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Timeout    <= 1'b0;
            ProgDone   <= 1'b0;
            CycleCount <= 16'd0;
        end else begin
            ProgDone <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (Start) begin
                        idx_q      <= 2'd0;
                        load_cnt_q <= 16'd0;
                        Done       <= 1'b0;
                        Timeout    <= 1'b0;
                        CycleCount <= 16'd0;
                        Init       <= 1'b1;
                        ProgState  <= 2'd0;
                        Busy       <= 1'b1;
                        state_q    <= StLoad;
                    end
                end
                StLoad: begin
                    if (load_cnt_q == LoadLast) begin
                        Init      <= 1'b0;
                        run_cnt_q <= 16'd0;
                        state_q   <= StRun;
                    end else begin
                        load_cnt_q <= load_cnt_q + 16'd1;
                    end
                end
                StRun: begin
                    run_cnt_q <= run_inc;
                    // Halt takes priority over the limit so a program ending on the
                    // last allowed cycle still counts as a normal completion.
                    if (halt_seen) begin
                        CycleCount <= run_inc;
                        ProgDone   <= 1'b1;
                        Init       <= 1'b1;
                        state_q    <= StNext;
                    end else if (limit_hit) begin
                        Timeout   <= 1'b1;
                        Done      <= 1'b1;
                        Init      <= 1'b1;
                        ProgState <= 2'd0;
                        Busy      <= 1'b0;
                        state_q   <= StDone;
                    end
                end
                StNext: begin
                    if (idx_q == LastIdx) begin
                        Done      <= 1'b1;
                        ProgState <= 2'd0;
                        Busy      <= 1'b0;
                        state_q   <= StDone;
                    end else begin
                        idx_q      <= idx_q + 2'd1;
                        ProgState  <= idx_q + 2'd1;
                        load_cnt_q <= 16'd0;
                        state_q    <= StLoad;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
